ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

PS/2 host-to-device transmitter that sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. It is the outbound counterpart of the inbound `keyboard_tracker` path and shares the PS2_CLK/PS2_DAT pins through open-drain enables. The block performs the full host-request framing: clock inhibit, request-to-send, 8 data bits, odd parity, stop, and device acknowledge. It reports completion or failure with one-cycle pulses.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit length in `clock` cycles (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles from leaving INHIBIT to the end of WAIT_IDLE (15 ms at 50 MHz).

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send; sampled on accept.
- tx_valid  in  1  send request.
- tx_ready  out  1  high in IDLE; accept = tx_valid & tx_ready.
- tx_done  out  1  one-cycle pulse: frame sent and ACK seen.
- tx_error  out  1  one-cycle pulse: no ACK, or timeout.
- tx_busy  out  1  high in every state except IDLE; the top level uses it to gate the receiver.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_dat_in  in  1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release (Z).
- ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release (Z).

## Operation
- Pin inputs pass through a 2-flop synchronizer. A falling edge (fe) is registered high→low of the synchronized clock.
- Reset (async) values: tx_ready=1, tx_done=0, tx_error=0, tx_busy=0, both oe=0, state=IDLE.
- FSM:
  - IDLE: on accept, latch {parity, tx_data} into a 9-bit shift register and go to INHIBIT. Parity = ~^tx_data (odd).
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: one cycle with dat_oe=1 and clk_oe=1 (start bit low), then clk_oe=0 and go to XFER.
  - XFER: on fe #1..#9, set dat_oe = ~shift[0], then shift right. This sends bit0..bit7, then parity.
  - STOP: on fe #10, dat_oe=0 (stop bit 1).
  - ACK: on fe #11, sample synchronized data.
    - Data 0: go to WAIT_IDLE.
    - Data 1: pulse tx_error and go to IDLE.
  - WAIT_IDLE: when both synchronized lines are 1, pulse tx_done and go to IDLE.
- An fe counter (4 bit) counts 1..11 and clears on entry to INHIBIT.
- tx_valid outside IDLE is ignored. Only one byte is in flight.
- tx_done and tx_error are mutually exclusive and never both asserted.

## Timing
- Accept at cycle 0: clk_oe=1 from cycle 1 through cycle INHIBIT_CYCLES.
- Cycle INHIBIT_CYCLES+1: dat_oe=1 (RTS).
- Cycle INHIBIT_CYCLES+2: clk_oe=0.
- Pin falling edge to fe: 3 cycles. fe to dat_oe update: 1 cycle. This is well inside the ≥5 us half-period of the device clock.
- tx_ready returns high the cycle after the tx_done/tx_error pulse.
- Reset mid-frame: both oe drop to 0 asynchronously and no done/error pulse is issued.

## Configuration
- PS2_TX_TIMEOUT_EN:
  - Defined: a 20-bit counter runs from INHIBIT exit. Reaching TIMEOUT_CYCLES in RTS/XFER/STOP/ACK/WAIT_IDLE releases both lines, pulses tx_error, and returns to IDLE.
  - Undefined: no counter is built, and the FSM waits indefinitely for device clocks.

## Structure
- Package ps2_pkg:
  - FSM state enum (IDLE, INHIBIT, RTS, XFER, STOP, ACK, WAIT_IDLE).
  - FE_ACK=11 and FE_STOP=10 constants.
  - Odd-parity function.
- Sub-module ps2_sync_edge: 2-flop synchronizer for clock and data plus falling-edge pulse. The receiver path reuses it.
- The top level maps each oe to `inout` as: PS2_x = oe ? 0 : Z.

## Test plan
- Send 0xED (device model clocks at 12.5 kHz, ACKs) → device sees start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; then tx_done pulses once.
- Send 0x07 → parity bit 0; send 0xFF → parity bit 1; tx_done for each back-to-back request.
- Device model holds data high at fe #11 → tx_error pulses, tx_done stays 0, both oe released.
- PS2_TX_TIMEOUT_EN defined, device never clocks → tx_error exactly TIMEOUT_CYCLES cycles after INHIBIT exit; undefined → tx_busy stays 1.
- tx_valid pulsed with 0x55 during XFER of 0xED → ignored; only 0xED is observed on the wire.
- Reset asserted after fe #5 → ps2_clk_oe=ps2_dat_oe=0 immediately, tx_ready=1; a new 0xF4 send then completes with tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame edge markers, parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        XFER,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    // Device falling-edge ordinals within a host-to-device frame
    localparam logic [3:0] FE_LAST_BIT = 4'd9;
    localparam logic [3:0] FE_STOP     = 4'd10;
    localparam logic [3:0] FE_ACK      = 4'd11;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a registered
// falling-edge pulse on the synchronized clock; shared with the receive path.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fe
);

    logic clk_meta;
    logic clk_prev;
    logic dat_meta;

    // Lines idle high, so reset to 1 to avoid a spurious edge after reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            clk_fe   <= 1'b0;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
            clk_fe   <= clk_prev & ~clk_sync;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, RTS, 8 data, odd parity, stop, ACK).
// Optional `PS2_TX_TIMEOUT_EN adds a watchdog from inhibit exit to line idle.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       tx_busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = 20;

    logic             clk_sync;
    logic             dat_sync;
    logic             clk_fe;
    ps2_state_e       state;
    logic [8:0]       shift;
    logic [3:0]       fe_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [3:0]       fe_next_c;
    logic             timeout_hit_c;

    ps2_sync_edge u_sync (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .clk_sync   (clk_sync),
        .dat_sync   (dat_sync),
        .clk_fe     (clk_fe)
    );

    assign fe_next_c = fe_cnt + 4'd1;

`ifdef PS2_TX_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Watchdog counts every cycle spent after the inhibit window
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == IDLE || state == INHIBIT) begin
            to_cnt <= '0;
        end else if (!timeout_hit_c) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit_c = (state != IDLE) && (state != INHIBIT) &&
                           (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign timeout_hit_c  = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Frame sequencer; all handshake and pin-enable outputs are registered here
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift      <= '0;
            fe_cnt     <= '0;
            inh_cnt    <= '0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            tx_busy    <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (timeout_hit_c) begin
                state      <= IDLE;
                tx_error   <= 1'b1;
                tx_busy    <= 1'b0;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        // Ready lags IDLE entry by one cycle so a pulse cycle never accepts
                        tx_ready <= 1'b1;
                        if (tx_valid && tx_ready) begin
                            shift      <= {odd_parity(tx_data), tx_data};
                            fe_cnt     <= '0;
                            inh_cnt    <= '0;
                            tx_ready   <= 1'b0;
                            tx_busy    <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                            ps2_dat_oe <= 1'b1;
                            state      <= RTS;
                        end else begin
                            inh_cnt <= inh_cnt + INH_W'(1);
                        end
                    end
                    RTS: begin
                        ps2_clk_oe <= 1'b0;
                        state      <= XFER;
                    end
                    XFER: begin
                        if (clk_fe) begin
                            fe_cnt     <= fe_next_c;
                            ps2_dat_oe <= ~shift[0];
                            shift      <= {1'b0, shift[8:1]};
                            if (fe_next_c == FE_LAST_BIT) begin
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        if (clk_fe) begin
                            fe_cnt     <= FE_STOP;
                            ps2_dat_oe <= 1'b0;
                            state      <= ACK;
                        end
                    end
                    ACK: begin
                        if (clk_fe) begin
                            fe_cnt <= FE_ACK;
                            if (!dat_sync) begin
                                state <= WAIT_IDLE;
                            end else begin
                                tx_error <= 1'b1;
                                tx_busy  <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_sync && dat_sync) begin
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks frames
// out of the host and each byte is compared with its expected framing.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TMO = 3000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, tx_busy;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       clk_line, dat_line;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_err = 0;
    bit pulse_q = 1'b0;

    assign clk_line = ps2_clk_oe ? 1'b0 : dev_clk;
    assign dat_line = ps2_dat_oe ? 1'b0 : dev_dat;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock      (clk),
        .reset      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .tx_busy    (tx_busy),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse bookkeeping and per-pulse handshake rules
    always @(negedge clk) begin
        if (!rst_n) begin
            pulse_q = 1'b0;
        end else begin
            if (pulse_q) check("ready_after_pulse", 32'(tx_ready), 32'd1);
            if (tx_done || tx_error) begin
                check("pulse_exclusive", 32'(tx_done & tx_error), 32'd0);
                check("ready_in_pulse", 32'(tx_ready), 32'd0);
                check("busy_in_pulse", 32'(tx_busy), 32'd0);
            end
            if (tx_done) n_done++;
            if (tx_error) n_err++;
            pulse_q = tx_done | tx_error;
        end
    end

    // Present a byte until accepted; returns at the negedge of the first post-accept cycle
    task automatic send(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Device side: wait for RTS, clock n_falls edges, sample on each rising edge
    task automatic dev_receive(input bit ack, input int n_falls, output logic [10:0] bits, output bit ok);
        ok = 1'b0;
        bits = 'x;
        for (int i = 0; i < 4000; i++) begin
            if (clk_line && !dat_line) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("rts_wait", 32'd0, 32'd1);
            return;
        end
        repeat (H) @(negedge clk);
        bits[0] = dat_line;
        for (int k = 1; k <= n_falls; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (k <= 10) bits[k] = dat_line;
            dev_clk = 1'b1;
            if (k == 10 && ack) begin
                repeat (H / 2) @(negedge clk);
                dev_dat = 1'b0;
                repeat (H / 2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        dev_dat = 1'b1;
    endtask

    // Pin enables from accept through RTS
    task automatic inhibit_timing();
        int bad;
        check("busy_after_accept", 32'(tx_busy), 32'd1);
        check("ready_after_accept", 32'(tx_ready), 32'd0);
        bad = 0;
        for (int c = 1; c <= INH; c++) begin
            if (!ps2_clk_oe || ps2_dat_oe) bad++;
            if (c < INH) @(negedge clk);
        end
        check("inhibit_window", 32'(bad), 32'd0);
        @(negedge clk);
        check("rts_dat_oe", 32'(ps2_dat_oe), 32'd1);
        check("rts_clk_oe", 32'(ps2_clk_oe), 32'd1);
        @(negedge clk);
        check("rts_clk_release", 32'(ps2_clk_oe), 32'd0);
        check("rts_start_held", 32'(ps2_dat_oe), 32'd1);
    endtask

    task automatic do_frame(input logic [7:0] d, input bit ack, input bit timing, input bit poke);
        logic [10:0] bits;
        bit ok;
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        send(d, ok);
        if (!ok) return;
        if (timing) inhibit_timing();
        if (poke) begin
            fork
                dev_receive(ack, 11, bits, ok);
                begin
                    repeat (200) @(negedge clk);
                    tx_data  = 8'h55;
                    tx_valid = 1'b1;
                    repeat (4) @(negedge clk);
                    tx_valid = 1'b0;
                end
            join
        end else begin
            dev_receive(ack, 11, bits, ok);
        end
        if (!ok) return;
        check("start_bit", 32'(bits[0]), 32'd0);
        check("data_byte", 32'(bits[8:1]), 32'(d));
        check("parity_bit", 32'(bits[9]), ($countones(d) % 2 == 0) ? 32'd1 : 32'd0);
        check("stop_bit", 32'(bits[10]), 32'd1);
        for (int i = 0; i < 200 && n_done == d0 && n_err == e0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("done_count", 32'(n_done - d0), ack ? 32'd1 : 32'd0);
        check("error_count", 32'(n_err - e0), ack ? 32'd0 : 32'd1);
        check("clk_oe_released", 32'(ps2_clk_oe), 32'd0);
        check("dat_oe_released", 32'(ps2_dat_oe), 32'd0);
        check("busy_after_frame", 32'(tx_busy), 32'd0);
    endtask

    initial begin
        logic [10:0] bits;
        bit ok;
        int e0, t, busy_seen;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(tx_ready), 32'd1);

        do_frame(8'hED, 1'b1, 1'b1, 1'b0);
        do_frame(8'h07, 1'b1, 1'b0, 1'b0);
        do_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        do_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        do_frame(8'hED, 1'b1, 1'b0, 1'b1);

        // The ignored 0x55 request must not have started a second frame
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_busy) busy_seen++;
            @(negedge clk);
        end
        check("no_extra_frame", 32'(busy_seen), 32'd0);

        // Reset after the fifth device clock
        send(8'($urandom), ok);
        dev_receive(1'b1, 5, bits, ok);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        rst_n   = 1'b1;
        repeat (3) @(negedge clk);
        do_frame(8'hF4, 1'b1, 1'b0, 1'b0);

        // Device never clocks
        e0 = n_err;
        send(8'($urandom), ok);
        for (int i = 0; i < INH + 20 && !ps2_dat_oe; i++) @(negedge clk);
        check("rts_seen", 32'(ps2_dat_oe), 32'd1);
`ifdef PS2_TX_TIMEOUT_EN
        t = 0;
        while (!tx_error && t < TMO + 100) begin
            @(negedge clk);
            t++;
        end
        check("timeout_cycles", 32'(t), 32'(TMO));
        @(negedge clk);
        check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("timeout_err_count", 32'(n_err - e0), 32'd1);
`else
        t = 0;
        repeat (TMO + 500) @(negedge clk);
        check("busy_held", 32'(tx_busy), 32'd1);
        check("no_timeout_error", 32'(n_err - e0 + t), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
`endif
        do_frame(8'($urandom), 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
